wide_add_seq: RTL
=================

Name: wide_add_seq

Overview:
- Multi-cycle wide adder that sits directly upstream of, and wraps, the 64-bit carry-select adder datapath.
- Accepts a W-bit operand pair over a valid/ready handshake and processes one 64-bit slice per clock, LSB first, chaining the carry through a register.
- Presents the full sum, carry-out and signed-overflow flag over a second valid/ready handshake.
- Purpose: widths beyond 64 bits without a W-bit combinational carry chain.

Parameters:
SLICE_W, 64, width of one adder slice (bits)
NUM_SLICES, 4, slices per operation; total width W = SLICE_W*NUM_SLICES (default 256)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair and cin valid
in_ready  output  1  block can accept an operand pair
a  input  W  operand A (unsigned or two's complement)
b  input  W  operand B
cin  input  1  carry into slice 0
out_valid  output  1  sum/cout/ovf valid
out_ready  input  1  consumer accepts result
sum  output  W  a+b+cin, modulo 2^W
cout  output  1  carry out of bit W-1
ovf  output  1  signed overflow of the W-bit add
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (asynchronous, rst high):
  - state=IDLE; slice index=0; carry reg=0; sum=0; cout=0; ovf=0; out_valid=0.
  - in_ready=1 and busy=0 while in IDLE.
  - Applies at any point, including mid-RUN or in DONE; the in-flight operation is discarded.
- States: IDLE, RUN, DONE (enum in package).
- in_ready = (state==IDLE), combinational from state. out_valid = (state==DONE), registered.
- IDLE:
  - On in_valid&&in_ready: latch a, b and cin into internal regs; carry reg<=cin; idx<=0; go to RUN.
  - a, b and cin are sampled only on that edge. Changes afterwards are ignored.
- RUN, one slice per cycle:
  - {c, s} = a_r[idx*SLICE_W +: SLICE_W] + b_r[same] + carry.
  - sum[idx slice] <= s; carry <= c; idx <= idx+1.
- On the edge that processes idx==NUM_SLICES-1:
  - cout <= c.
  - ovf <= (a_r[W-1]==b_r[W-1]) && (s[SLICE_W-1]!=a_r[W-1]).
  - Go to DONE.
- Latency: accept edge at cycle 0 -> out_valid high after edge NUM_SLICES (4 cycles at default).
- DONE:
  - sum, cout and ovf are held stable while out_valid=1.
  - On out_valid&&out_ready: go to IDLE and drop out_valid on that edge.
  - in_ready is 0 throughout DONE; a new operation cannot be accepted in the same cycle as the result is taken.
  - Minimum issue interval = NUM_SLICES+2 cycles.
- During RUN, sum shows partially updated slices. Consumers must qualify with out_valid.
- in_valid while busy: ignored, no effect.
- idx width = max(1,$clog2(NUM_SLICES)). NUM_SLICES=1 is legal: RUN lasts one cycle.
- Arithmetic is unsigned modulo 2^W. cout and ovf are both always produced; the consumer chooses the interpretation.

Decomposition:
- Package wide_add_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default SLICE_W and NUM_SLICES localparams;
  - idx width function.
- One sub-module, csel_slice64: a SLICE_W-bit carry-select adder with cin input and cout output, purely combinational, instantiated once and time-shared across slices.
- FSM, operand registers and result registers live in wide_add_seq.

Test Plan:
- Small operands: a=998, b=128, cin=0 -> out_valid 4 cycles after accept; sum=1126, cout=0, ovf=0.
- Cross-slice carry: a=2^64-1, b=1 -> sum=2^64 (bit 64 set, all other bits 0), cout=0; repeat with cin=1 and a=b=0 -> sum=1.
- Full-width wrap: a=2^256-1, b=1 -> sum=0, cout=1, ovf=0. Signed overflow: a=2^255-1, b=1 -> sum=2^255, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> out_valid held, sum unchanged, in_ready=0, new operands not taken. Release out_ready -> IDLE next edge, then the new pair is accepted.
- Reset mid-operation: assert rst during RUN at idx=2 -> outputs go to 0 asynchronously, out_valid=0, in_ready=1. The next operation a=9998, b=9028 gives sum=19026.
- Operand stability: change a and b every cycle during RUN -> the result reflects only the values latched on the accept edge.

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared types and defaults for the sequential wide adder: FSM states,
// default slice geometry and the slice-index width helper.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_SLICE_W    = 64;
    localparam int DEF_NUM_SLICES = 4;

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_w(input int num_slices);
        return (num_slices > 1) ? $clog2(num_slices) : 1;
    endfunction

endpackage

// File: rtl/csel_slice64.sv
// Purely combinational carry-select adder for one slice: the low half ripples,
// the high half is precomputed for both carries and selected by the low carry.
module csel_slice64 #(
    parameter int SLICE_W = 64
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    localparam int HALF = SLICE_W / 2;
    localparam int HI   = SLICE_W - HALF;

    logic [HALF:0] w_lo;
    logic [HI:0]   w_hi0;
    logic [HI:0]   w_hi1;

    assign w_lo  = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, cin};
    assign w_hi0 = {1'b0, a[SLICE_W-1:HALF]} + {1'b0, b[SLICE_W-1:HALF]};
    assign w_hi1 = {1'b0, a[SLICE_W-1:HALF]} + {1'b0, b[SLICE_W-1:HALF]} + {{HI{1'b0}}, 1'b1};

    assign s    = {(w_lo[HALF] ? w_hi1[HI-1:0] : w_hi0[HI-1:0]), w_lo[HALF-1:0]};
    assign cout = w_lo[HALF] ? w_hi1[HI] : w_hi0[HI];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle W-bit adder: one SLICE_W slice per clock, LSB first, carry chained
// through a register, sharing a single carry-select slice adder.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// RUN   | adding slice r_idx, one slice per clock
// DONE  | result held with out_valid high until out_ready
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter  int SLICE_W    = DEF_SLICE_W,
    parameter  int NUM_SLICES = DEF_NUM_SLICES,
    localparam int W          = SLICE_W * NUM_SLICES,
    localparam int IDX_W      = idx_w(NUM_SLICES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         busy
);

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic               w_take;
    logic [SLICE_W-1:0] w_a_slice;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W-1:0] w_s;
    logic               w_c;

    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int k = 0; k < NUM_SLICES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_slice = r_a[k*SLICE_W +: SLICE_W];
                w_b_slice = r_b[k*SLICE_W +: SLICE_W];
            end
        end
    end

    csel_slice64 #(.SLICE_W(SLICE_W)) u_slice (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    assign w_last = (r_idx == IDX_W'(NUM_SLICES - 1));

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_take       = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_last) w_next_state = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_take       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_idx   <= '0;
            end
            if (w_step) begin
                for (int k = 0; k < NUM_SLICES; k++) begin
                    if (r_idx == IDX_W'(k)) r_sum[k*SLICE_W +: SLICE_W] <= w_s;
                end
                r_carry <= w_c;
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    r_cout      <= w_c;
                    // Signed overflow: equal operand signs, result sign differs.
                    r_ovf       <= (r_a[W-1] == r_b[W-1]) && (w_s[SLICE_W-1] != r_a[W-1]);
                    r_out_valid <= 1'b1;
                end
            end
            if (w_take) r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
